mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sequential bus-access stage between the core's execute/control path and the single-port data memory bus. Accepts one load or store request per transaction and turns it into a word-aligned bus request with byte strobes. Waits on the memory ready handshake.
- For loads, captures the raw 32-bit memory word together with the original address and funct3. These are presented as rsp_rdata, rsp_addr and rsp_funct3 to the downstream load data extractor, which does the sign/zero extension.
- Detects misaligned accesses and never issues them to the bus.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_ready; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  core requests an access; sampled only in IDLE.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V load/store funct3.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- mem_valid  output  1  bus request valid.
- mem_ready  input  1  memory completes the request in the cycle it is high with mem_valid.
- mem_addr  output  32  word-aligned address: {req_addr[31:2], 2'b00}.
- mem_wdata  output  32  store data shifted to its byte lane.
- mem_wstrb  output  4  byte write enables; 4'b0000 for loads.
- mem_rdata  input  32  read word, valid when mem_ready is high.
- rsp_valid  output  1  one-cycle pulse: transaction finished.
- rsp_rdata  output  32  captured raw read word; 0 for stores.
- rsp_addr  output  32  original byte address of the transaction.
- rsp_funct3  output  3  original funct3.
- rsp_error  output  1  qualifies rsp_valid: misaligned access, illegal funct3, or timeout.

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE. mem_valid, rsp_valid and rsp_error = 0. mem_addr, mem_wdata, mem_wstrb, rsp_rdata, rsp_addr and rsp_funct3 = 0.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, latch req_write, req_funct3 and req_addr into rsp_addr/rsp_funct3 and compute the bus fields.
  - Legal loads are funct3 000, 001, 010, 100, 101. Legal stores are 000, 001, 010.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal or misaligned request: go to RESP with rsp_error = 1; mem_valid stays 0.
  - Otherwise: go to BUS with mem_valid = 1 from the next cycle.
- Store strobes:
  - SB: 4'b0001 << addr[1:0], with wdata[7:0] replicated to all four lanes.
  - SH: 4'b0011 << addr[1:0], with wdata[15:0] replicated to both halves.
  - SW: 4'b1111, wdata passed through unchanged.
- BUS:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready.
  - When mem_ready is high: rsp_rdata = load ? mem_rdata : 0. mem_valid drops in the following cycle. Go to RESP.
  - mem_ready while mem_valid is 0 is ignored.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE; req_ready reasserts in that next cycle.
  - rsp_rdata, rsp_addr, rsp_funct3 and rsp_error hold their values until the next accept.
  - rsp_error is cleared on the next accept.
- Latency:
  - Accept to mem_valid: 1 cycle.
  - mem_ready to rsp_valid: 1 cycle.
  - Minimum accept to rsp_valid: 2 cycles with zero-wait memory.
  - Error path accept to rsp_valid: 1 cycle.
  - Back-to-back throughput: one transaction per 3 cycles.
- Requests presented while not in IDLE are not accepted and have no effect.
- Reset asserted mid-transaction: return to IDLE immediately. mem_valid drops asynchronously and no rsp_valid is produced for the aborted access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to BUS and increments each BUS cycle without mem_ready.
  - On reaching TIMEOUT_CYCLES: mem_valid drops, go to RESP with rsp_error = 1 and rsp_rdata = 0.
  - mem_ready in the same cycle as the timeout takes priority, giving a normal completion.
- Not defined: no counter; BUS waits indefinitely.

Test Plan:
- LW, addr 0x0000_0104, mem_ready 1 cycle after mem_valid, mem_rdata 0xDEAD_BEEF -> mem_addr 0x104, mem_wstrb 0000; rsp_valid 1 cycle later with rsp_rdata 0xDEAD_BEEF, rsp_addr 0x104, rsp_funct3 010, rsp_error 0.
- SB, addr 0x203, wdata 0x0000_00A5 -> mem_addr 0x200, mem_wstrb 1000, mem_wdata 0xA5A5_A5A5; rsp_rdata 0.
- SH, addr 0x302, wdata 0x1234 with 3 wait cycles -> mem_wstrb 1100, mem_wdata 0x1234_1234; bus outputs stable all 4 BUS cycles; rsp_valid 1 cycle after mem_ready.
- LW, addr 0x101 and LH, addr 0x103 -> mem_valid never asserted; rsp_valid with rsp_error 1 one cycle after accept; funct3 011 -> same error response.
- Reset asserted during BUS of a load -> mem_valid 0 immediately, req_ready 1 after release, no rsp_valid pulse.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES 4, mem_ready held 0 -> mem_valid drops after 4 BUS cycles, rsp_error 1. Repeat with mem_ready on the 4th cycle -> normal completion, rsp_error 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store bus-access stage: turns one core request into a word-aligned, strobed memory bus transaction.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] rsp_addr,
  output logic [2:0]  rsp_funct3,
  output logic        rsp_error
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [2:0]  rsp_funct3_q, rsp_funct3_d;
  logic        rsp_error_q, rsp_error_d;
  logic        legal, misaligned, timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    timeout = (state_q == BUS) && !mem_ready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    if (state_q == IDLE) cnt_d = '0;
    else if (state_q == BUS && !mem_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_write;
      default:                legal = 1'b0;
    endcase
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  end

  // Bus fields are computed once at accept and then held for the whole BUS phase.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_funct3_d = rsp_funct3_q;
    rsp_error_d  = rsp_error_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          rsp_addr_d   = req_addr;
          rsp_funct3_d = req_funct3;
          rsp_rdata_d  = '0;
          rsp_error_d  = 1'b0;
          if (!legal || misaligned) begin
            rsp_error_d = 1'b1;
            state_d     = RESP;
          end else begin
            state_d    = BUS;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (!req_write) begin
              mem_wstrb_d = 4'b0000;
              mem_wdata_d = '0;
            end else begin
              unique case (req_funct3[1:0])
                2'b00: begin
                  mem_wstrb_d = 4'b0001 << req_addr[1:0];
                  mem_wdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                  mem_wstrb_d = 4'b0011 << req_addr[1:0];
                  mem_wdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                  mem_wstrb_d = 4'b1111;
                  mem_wdata_d = req_wdata;
                end
              endcase
            end
          end
        end
      end
      BUS: begin
        if (mem_ready) begin
          rsp_rdata_d = write_q ? 32'h0 : mem_rdata;
          state_d     = RESP;
        end else if (timeout) begin
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_addr_q   <= '0;
      rsp_funct3_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_funct3_q <= rsp_funct3_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_valid  = (state_q == BUS);
  assign rsp_valid  = (state_q == RESP);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_funct3 = rsp_funct3_q;
  assign rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, strobed stores, wait states, error paths and mid-access reset.
// The watchdog steps run only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk;
  logic        resetn;
  logic        reqValid, reqReady, reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWdata;
  logic        memValid, memReady;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWstrb;
  logic        rspValid, rspError;
  logic [31:0] rspRdata, rspAddr;
  logic [2:0]  rspFunct3;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
    .mem_valid(memValid), .mem_ready(memReady), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_wstrb(memWstrb), .mem_rdata(memRdata),
    .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_addr(rspAddr),
    .rsp_funct3(rspFunct3), .rsp_error(rspError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [2:0] funct3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    reqValid  = 1'b1;
    reqWrite  = write;
    reqFunct3 = funct3;
    reqAddr   = addr;
    reqWdata  = wdata;
    step();
    reqValid  = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = 3'b0;
    reqAddr = '0; reqWdata = '0; memReady = 1'b0; memRdata = '0;
    #3;
    checkOutput("reset_req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset_mem_valid", 32'(memValid), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset_rsp_error", 32'(rspError), 32'd0);
    checkOutput("reset_mem_addr", memAddr, 32'h0);
    checkOutput("reset_rsp_rdata", rspRdata, 32'h0);
    step();
    resetn = 1'b1;
    step();

    // LW 0x104 with one wait cycle
    applyStimulus(1'b0, 3'b010, 32'h104, 32'h0);
    checkOutput("lw_mem_valid", 32'(memValid), 32'd1);
    checkOutput("lw_req_ready", 32'(reqReady), 32'd0);
    checkOutput("lw_mem_addr", memAddr, 32'h104);
    checkOutput("lw_mem_wstrb", 32'(memWstrb), 32'h0);
    step();
    checkOutput("lw_wait_mem_valid", 32'(memValid), 32'd1);
    checkOutput("lw_wait_rsp_valid", 32'(rspValid), 32'd0);
    memReady = 1'b1; memRdata = 32'hDEAD_BEEF;
    step();
    memReady = 1'b0; memRdata = 32'h0;
    checkOutput("lw_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("lw_mem_valid_drop", 32'(memValid), 32'd0);
    checkOutput("lw_rsp_rdata", rspRdata, 32'hDEAD_BEEF);
    checkOutput("lw_rsp_addr", rspAddr, 32'h104);
    checkOutput("lw_rsp_funct3", 32'(rspFunct3), 32'd2);
    checkOutput("lw_rsp_error", 32'(rspError), 32'd0);
    step();
    checkOutput("lw_rsp_pulse_end", 32'(rspValid), 32'd0);
    checkOutput("lw_req_ready_back", 32'(reqReady), 32'd1);
    checkOutput("lw_rsp_rdata_hold", rspRdata, 32'hDEAD_BEEF);

    // SB 0x203, zero-wait memory
    applyStimulus(1'b1, 3'b000, 32'h203, 32'h0000_00A5);
    checkOutput("sb_mem_addr", memAddr, 32'h200);
    checkOutput("sb_mem_wstrb", 32'(memWstrb), 32'h8);
    checkOutput("sb_mem_wdata", memWdata, 32'hA5A5_A5A5);
    memReady = 1'b1; memRdata = 32'h5555_5555;
    step();
    memReady = 1'b0;
    checkOutput("sb_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("sb_rsp_rdata", rspRdata, 32'h0);
    step();

    // SH 0x302 with three wait cycles; a competing request during BUS must be ignored
    applyStimulus(1'b1, 3'b001, 32'h302, 32'h0000_1234);
    reqValid = 1'b1; reqWrite = 1'b0; reqFunct3 = 3'b010; reqAddr = 32'h900;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sh_bus%0d_mem_valid", i), 32'(memValid), 32'd1);
      checkOutput($sformatf("sh_bus%0d_mem_addr", i), memAddr, 32'h300);
      checkOutput($sformatf("sh_bus%0d_mem_wstrb", i), 32'(memWstrb), 32'hC);
      checkOutput($sformatf("sh_bus%0d_mem_wdata", i), memWdata, 32'h1234_1234);
      if (i == 3) begin
        memReady = 1'b1;
        reqValid = 1'b0;
      end
      step();
    end
    memReady = 1'b0;
    checkOutput("sh_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("sh_rsp_addr", rspAddr, 32'h302);
    checkOutput("sh_rsp_funct3", 32'(rspFunct3), 32'd1);
    step();
    checkOutput("sh_idle_mem_valid", 32'(memValid), 32'd0);

    // Misaligned and illegal requests: error response one cycle after accept, no bus activity
    applyStimulus(1'b0, 3'b010, 32'h101, 32'h0);
    checkOutput("lw_mis_mem_valid", 32'(memValid), 32'd0);
    checkOutput("lw_mis_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("lw_mis_rsp_error", 32'(rspError), 32'd1);
    checkOutput("lw_mis_rsp_addr", rspAddr, 32'h101);
    step();
    checkOutput("lw_mis_error_hold", 32'(rspError), 32'd1);
    applyStimulus(1'b0, 3'b001, 32'h103, 32'h0);
    checkOutput("lh_mis_mem_valid", 32'(memValid), 32'd0);
    checkOutput("lh_mis_rsp_error", 32'(rspError), 32'd1);
    step();
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0);
    checkOutput("f3_011_mem_valid", 32'(memValid), 32'd0);
    checkOutput("f3_011_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("f3_011_rsp_error", 32'(rspError), 32'd1);
    step();
    applyStimulus(1'b1, 3'b100, 32'h100, 32'h0);
    checkOutput("sbu_illegal_rsp_error", 32'(rspError), 32'd1);
    checkOutput("sbu_illegal_mem_valid", 32'(memValid), 32'd0);
    step();

    // LBU 0x107 clears the previous error on accept
    applyStimulus(1'b0, 3'b100, 32'h107, 32'h0);
    checkOutput("lbu_error_cleared", 32'(rspError), 32'd0);
    checkOutput("lbu_mem_addr", memAddr, 32'h104);
    checkOutput("lbu_mem_wstrb", 32'(memWstrb), 32'h0);
    memReady = 1'b1; memRdata = 32'h1122_3344;
    step();
    memReady = 1'b0;
    checkOutput("lbu_rsp_rdata", rspRdata, 32'h1122_3344);
    checkOutput("lbu_rsp_funct3", 32'(rspFunct3), 32'd4);
    step();

    // Reset during BUS of a load aborts it with no response
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0);
    checkOutput("rst_bus_mem_valid", 32'(memValid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst_async_mem_valid", 32'(memValid), 32'd0);
    checkOutput("rst_async_mem_addr", memAddr, 32'h0);
    step();
    resetn = 1'b1;
    checkOutput("rst_release_req_ready", 32'(reqReady), 32'd1);
    memReady = 1'b1; memRdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("rst_no_rsp%0d", i), 32'(rspValid), 32'd0);
    end
    memReady = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Watchdog: no mem_ready for 4 BUS cycles gives an error response
    applyStimulus(1'b0, 3'b010, 32'h500, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_bus%0d_mem_valid", i), 32'(memValid), 32'd1);
      step();
    end
    checkOutput("to_mem_valid_drop", 32'(memValid), 32'd0);
    checkOutput("to_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("to_rsp_error", 32'(rspError), 32'd1);
    checkOutput("to_rsp_rdata", rspRdata, 32'h0);
    step();
    // mem_ready on the 4th BUS cycle wins over the watchdog
    applyStimulus(1'b0, 3'b010, 32'h500, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tr_bus%0d_mem_valid", i), 32'(memValid), 32'd1);
      if (i == 3) begin
        memReady = 1'b1;
        memRdata = 32'hCAFE_F00D;
      end
      step();
    end
    memReady = 1'b0;
    checkOutput("tr_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("tr_rsp_error", 32'(rspError), 32'd0);
    checkOutput("tr_rsp_rdata", rspRdata, 32'hCAFE_F00D);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
